// File: rtl/noc_pkg.sv
// Shared NoC link definitions: flit type encoding, type-field location and
// transmitter state encoding. The downstream receive FIFO imports this too.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_t;

    // The type field occupies the top FLIT_TYPE_W bits of every flit.
    localparam int unsigned FLIT_TYPE_W = 2;

    function automatic int unsigned flit_type_lsb(input int unsigned data_width);
        return data_width - FLIT_TYPE_W;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } tx_state_t;

endpackage

// File: rtl/credit_counter.sv
// Free-slot counter for the downstream FIFO. It saturates at DEPTH and flags
// an unmatched credit return as overflow.
module credit_counter
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   dec,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic          w_inc_only;
    logic          w_dec_only;

    assign w_inc_only = inc && !dec;
    assign w_dec_only = dec && !inc;
    assign overflow   = w_inc_only && (r_count == FULL);
    assign count      = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= FULL;
        end else if (w_dec_only && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end else if (w_inc_only && (r_count != FULL)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/link_credit_tx.sv
// Credit-based link transmitter: forwards flits one cycle late while credits
// remain, tracks packet framing and raises a sticky protocol error flag.
module link_credit_tx
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_flit,
    output logic                   in_ready,
    output logic                   link_valid,
    output logic [DATA_WIDTH-1:0]  link_flit,
    input  logic                   credit_return,
    output logic [$clog2(DEPTH):0] credits,
    output logic                   pkt_active,
    output logic                   credit_err
);

    localparam int unsigned TYPE_LSB = flit_type_lsb(DATA_WIDTH);

    logic                  w_xfer;
    logic                  w_overflow;
    logic                  w_type_err;
    flit_type_t            w_type;
    tx_state_t             w_state_nxt;
    tx_state_t             r_state;
    logic                  r_link_valid;
    logic [DATA_WIDTH-1:0] r_link_flit;
    logic                  r_credit_err;

    credit_counter #(
        .DEPTH (DEPTH)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (credit_return),
        .dec      (w_xfer),
        .count    (credits),
        .overflow (w_overflow)
    );

    // Ready depends only on the registered credit count.
    assign in_ready = (credits != '0);
    assign w_xfer   = in_valid && in_ready;
    assign w_type   = flit_type_t'(in_flit[TYPE_LSB +: FLIT_TYPE_W]);

    always_comb begin
        w_state_nxt = r_state;
        w_type_err  = 1'b0;
        if (w_xfer) begin
            unique case (w_type)
                FLIT_HEAD: begin
                    w_type_err  = (r_state == ST_PACKET);
                    w_state_nxt = ST_PACKET;
                end
                FLIT_HEAD_TAIL: begin
                    w_type_err  = (r_state == ST_PACKET);
                    w_state_nxt = ST_IDLE;
                end
                FLIT_BODY: begin
                    w_type_err  = (r_state == ST_IDLE);
                end
                FLIT_TAIL: begin
                    w_type_err  = (r_state == ST_IDLE);
                    w_state_nxt = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_link_valid <= 1'b0;
            r_link_flit  <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_link_valid <= w_xfer;
            if (w_xfer) begin
                r_link_flit <= in_flit;
            end
            if (w_overflow || w_type_err) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign link_valid = r_link_valid;
    assign link_flit  = r_link_flit;
    assign pkt_active = (r_state == ST_PACKET);
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_link_credit_tx.sv
// Scoreboard bench for link_credit_tx: a reference model predicts credits,
// framing state and the error flag; forwarded flits are queued and matched.
module tb_link_credit_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_flit;
    logic          in_ready;
    logic          link_valid;
    logic [DW-1:0] link_flit;
    logic          credit_return;
    logic [2:0]    credits;
    logic          pkt_active;
    logic          credit_err;

    int errors = 0;
    int checks = 0;

    int            m_credits;
    logic          m_pkt;
    logic          m_err;
    logic [DW-1:0] sbq[$];

    link_credit_tx #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_flit       (in_flit),
        .in_ready      (in_ready),
        .link_valid    (link_valid),
        .link_flit     (link_flit),
        .credit_return (credit_return),
        .credits       (credits),
        .pkt_active    (pkt_active),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
        return {t, p};
    endfunction

    task automatic model_reset();
        m_credits = DEPTH;
        m_pkt     = 1'b0;
        m_err     = 1'b0;
        sbq.delete();
    endtask

    // One clock of stimulus, then checks of every registered output.
    task automatic step(input logic v, input logic [DW-1:0] f, input logic ret);
        logic          exp_x;
        logic [DW-1:0] exp_f;
        in_valid      = v;
        in_flit       = f;
        credit_return = ret;
        #1;
        checks++;
        if (in_ready !== (m_credits != 0)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, (m_credits != 0));
        end
        exp_x = v && (m_credits != 0);
        if (exp_x) sbq.push_back(f);
        @(posedge clk);
        #1;
        if (exp_x) begin
            case (f[31:30])
                2'b00: begin if (m_pkt) m_err = 1'b1; m_pkt = 1'b1; end
                2'b01: begin if (!m_pkt) m_err = 1'b1; end
                2'b10: begin if (!m_pkt) m_err = 1'b1; m_pkt = 1'b0; end
                default: begin if (m_pkt) m_err = 1'b1; m_pkt = 1'b0; end
            endcase
        end
        if (exp_x && !ret) m_credits--;
        else if (ret && !exp_x) begin
            if (m_credits == DEPTH) m_err = 1'b1;
            else m_credits++;
        end
        checks++;
        if (link_valid !== exp_x) begin
            errors++;
            $display("FAIL link_valid: got %b want %b", link_valid, exp_x);
        end
        if (link_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL link_flit: got %h with empty scoreboard", link_flit);
            end else begin
                exp_f = sbq.pop_front();
                if (link_flit !== exp_f) begin
                    errors++;
                    $display("FAIL link_flit: got %h want %h", link_flit, exp_f);
                end
            end
        end
        checks++;
        if (credits !== 3'(m_credits)) begin
            errors++;
            $display("FAIL credits: got %0d want %0d", credits, m_credits);
        end
        checks++;
        if (pkt_active !== m_pkt) begin
            errors++;
            $display("FAIL pkt_active: got %b want %b", pkt_active, m_pkt);
        end
        checks++;
        if (credit_err !== m_err) begin
            errors++;
            $display("FAIL credit_err: got %b want %b", credit_err, m_err);
        end
    endtask

    // Asynchronous reset asserted between edges; values must settle at once.
    task automatic test_reset(input logic v, input logic [DW-1:0] f);
        in_valid      = v;
        in_flit       = f;
        credit_return = 1'b0;
        reset         = 1'b1;
        #1;
        checks++;
        if (credits !== 3'(DEPTH) || in_ready !== 1'b1 || link_valid !== 1'b0 ||
            link_flit !== '0 || pkt_active !== 1'b0 || credit_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got credits=%0d rdy=%b lv=%b lf=%h pkt=%b err=%b want 4 1 0 0 0 0",
                     credits, in_ready, link_valid, link_flit, pkt_active, credit_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (link_valid !== 1'b0 || credits !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL reset_hold: got lv=%b credits=%0d want 0 4", link_valid, credits);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_and_stall();
        for (int i = 0; i < 4; i++) step(1'b1, mk(2'b11, 30'(32'h100 + i)), 1'b0);
        step(1'b1, mk(2'b11, 30'h1ab), 1'b0);
        step(1'b1, mk(2'b11, 30'h1ab), 1'b0);
    endtask

    task automatic test_return_releases();
        step(1'b1, mk(2'b11, 30'h1ab), 1'b1);
        step(1'b1, mk(2'b11, 30'h1ab), 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_simultaneous();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, mk(2'b11, 30'h2cd), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_packet();
        step(1'b1, mk(2'b00, 30'h10), 1'b0);
        step(1'b1, mk(2'b01, 30'h11), 1'b0);
        step(1'b1, mk(2'b01, 30'h12), 1'b0);
        step(1'b1, mk(2'b10, 30'h13), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_overflow();
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, mk(2'b11, 30'(32'h300 + i)), 1'b1);
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_type_errors();
        step(1'b1, mk(2'b01, 30'h40), 1'b1);
        test_reset(1'b0, '0);
        step(1'b1, mk(2'b10, 30'h41), 1'b0);
        test_reset(1'b0, '0);
        step(1'b1, mk(2'b00, 30'h42), 1'b0);
        step(1'b1, mk(2'b00, 30'h43), 1'b0);
        step(1'b1, mk(2'b11, 30'h44), 1'b1);
        test_reset(1'b0, '0);
    endtask

    task automatic test_reset_mid_packet();
        step(1'b1, mk(2'b00, 30'h50), 1'b0);
        step(1'b1, mk(2'b01, 30'h51), 1'b0);
        test_reset(1'b1, mk(2'b01, 30'h52));
    endtask

    task automatic test_back_to_back();
        logic [1:0] t;
        for (int i = 0; i < 200; i++) begin
            t = m_pkt ? (($urandom_range(0, 2) == 0) ? 2'b10 : 2'b01)
                      : (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
            step(($urandom_range(0, 3) != 0), mk(t, 30'($urandom)),
                 (m_credits < DEPTH) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_flit       = '0;
        credit_return = 1'b0;
        model_reset();
        #12;
        test_reset(1'b0, '0);
        test_fill_and_stall();
        test_return_releases();
        test_simultaneous();
        test_packet();
        test_overflow();
        test_reset(1'b0, '0);
        test_type_errors();
        test_reset_mid_packet();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
